// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] EXC_VECTOR_DEF   = 32'h8000_0180;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   // Winning redirect after priority selection; target already word aligned.
   typedef struct packed {
      logic            valid;
      logic            exc;
      logic [XLEN-1:0] target;
   } redirect_t;

endpackage

// File: rtl/redirect_arbiter.sv
// Priority select of exception > branch > jump redirects, with target alignment.
module redirect_arbiter
   import fetch_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
)
(
   input  logic            exc_valid,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_target,
   output redirect_t       redirect_c
);

   always_comb begin
      redirect_c = '0;
      if (exc_valid) begin
         redirect_c.valid  = 1'b1;
         redirect_c.exc    = 1'b1;
         redirect_c.target = EXC_VECTOR;
      end else if (br_taken) begin
         redirect_c.valid  = 1'b1;
         redirect_c.target = br_target;
      end else if (jump_valid) begin
         redirect_c.valid  = 1'b1;
         redirect_c.target = jump_target;
      end
      redirect_c.target[1:0] = 2'b00;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC and issues one instruction-memory request at a time; applies
// redirects, holds the fetched word under stall and discards stale responses.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [XLEN-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              exc_valid,
   input  logic              br_taken,
   input  logic [XLEN-1:0]   br_target,
   input  logic              jump_valid,
   input  logic [XLEN-1:0]   jump_target,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   inst_pc,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   epc
);

   fetch_state_e      state, state_n;
   logic              kill, kill_n;
   logic              req_n, valid_n;
   logic [XLEN-1:0]   pc_n, addr_n, inst_pc_n, epc_n;
   logic [INST_W-1:0] inst_n;
   logic              handshake_c, consumed_c;
   redirect_t         redirect_c;

   redirect_arbiter #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
      .exc_valid   (exc_valid),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .redirect_c  (redirect_c)
   );

   assign handshake_c = imem_req & imem_ready;
   assign consumed_c  = inst_valid & ~stall;

   // Next-state and next-register computation.
   always_comb begin
      state_n   = state;
      kill_n    = kill;
      pc_n      = pc;
      addr_n    = imem_addr;
      inst_n    = inst;
      inst_pc_n = inst_pc;
      valid_n   = inst_valid;
      epc_n     = epc;
      req_n     = 1'b0;

      unique case (state)
         IDLE: state_n = REQ;
         REQ: begin
            if (consumed_c)  valid_n = 1'b0;
            if (handshake_c) state_n = WAIT;
         end
         WAIT: begin
            if (consumed_c) valid_n = 1'b0;
            if (imem_rvalid) begin
               if (kill) begin
                  kill_n = 1'b0;
               end else begin
                  inst_n    = imem_rdata;
                  inst_pc_n = imem_addr;
                  valid_n   = 1'b1;
                  pc_n      = pc + XLEN'(4);
               end
               state_n = (!kill && stall) ? HOLD : REQ;
            end
         end
         HOLD: begin
            if (!stall) begin
               valid_n = 1'b0;
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase

      // A redirect squashes the current word and any request already issued.
      if (redirect_c.valid) begin
         pc_n    = redirect_c.target;
         valid_n = 1'b0;
         if (redirect_c.exc) epc_n = inst_valid ? inst_pc : pc;
         case (state)
            REQ:  kill_n = 1'b1;
            WAIT: begin
               if (imem_rvalid) begin
                  kill_n  = 1'b0;
                  state_n = REQ;
               end else begin
                  kill_n = 1'b1;
               end
            end
            HOLD:    state_n = REQ;
            default: ;
         endcase
      end

      req_n = (state_n == REQ);
      // Address is latched on REQ entry and held until the handshake.
      if (state_n == REQ && state != REQ) addr_n = pc_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         kill       <= 1'b0;
         pc         <= RESET_VECTOR;
         imem_req   <= 1'b0;
         imem_addr  <= '0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         epc        <= '0;
      end else begin
         state      <= state_n;
         kill       <= kill_n;
         pc         <= pc_n;
         imem_req   <= req_n;
         imem_addr  <= addr_n;
         inst_valid <= valid_n;
         inst       <= inst_n;
         inst_pc    <= inst_pc_n;
         epc        <= epc_n;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a simple one-cycle memory responder.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        exc_valid;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'h0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] pc;
   logic [31:0] epc;

   logic        auto_resp;
   logic        man_rvalid;
   logic [31:0] man_rdata;
   logic        pending = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   int checks = 0;
   int errors = 0;

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .exc_valid   (exc_valid),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .pc          (pc),
      .epc         (epc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   // Memory: responds one cycle after each accepted request, or replays manual values.
   always @(posedge clk) begin
      pending   = imem_req & imem_ready & ~reset;
      pend_addr = imem_addr;
   end

   always @(negedge clk) begin
      if (auto_resp) begin
         imem_rvalid = pending;
         imem_rdata  = pending ? mem_word(pend_addr) : 32'h0;
      end else begin
         imem_rvalid = man_rvalid;
         imem_rdata  = man_rdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; exc_valid = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      jump_valid = 1'b0; jump_target = 32'h0; imem_ready = 1'b1;
      auto_resp = 1'b1; man_rvalid = 1'b0; man_rdata = 32'h0;

      tick(); tick();
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_pc", pc, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);

      // 1: zero-wait fetch
      reset = 1'b0;
      tick();
      check("t1_req", 32'(imem_req), 32'h1);
      check("t1_addr0", imem_addr, 32'h0);
      tick();
      check("t1_wait_req", 32'(imem_req), 32'h0);
      tick();
      check("t1_valid", 32'(inst_valid), 32'h1);
      check("t1_inst", inst, 32'hA500_0000);
      check("t1_inst_pc", inst_pc, 32'h0);
      check("t1_addr4", imem_addr, 32'h4);
      check("t1_pc", pc, 32'h4);
      tick();
      check("t1_consumed", 32'(inst_valid), 32'h0);

      // 2: stall while word @4 is presented
      stall = 1'b1;
      tick();
      check("t2_valid", 32'(inst_valid), 32'h1);
      check("t2_inst_pc", inst_pc, 32'h4);
      check("t2_inst", inst, 32'hA500_0004);
      check("t2_req", 32'(imem_req), 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t2_hold_valid", 32'(inst_valid), 32'h1);
         check("t2_hold_req", 32'(imem_req), 32'h0);
         check("t2_hold_pc", inst_pc, 32'h4);
      end
      stall = 1'b0;
      tick();
      check("t2_release_valid", 32'(inst_valid), 32'h0);
      check("t2_release_req", 32'(imem_req), 32'h1);
      check("t2_release_addr", imem_addr, 32'h8);

      // 3: branch during WAIT for 0x8, late stale response
      auto_resp = 1'b0; man_rvalid = 1'b0;
      tick();
      br_taken = 1'b1; br_target = 32'h100;
      tick();
      br_taken = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
      check("t3_pc", pc, 32'h100);
      check("t3_wait_valid", 32'(inst_valid), 32'h0);
      tick();
      man_rvalid = 1'b0; auto_resp = 1'b1;
      check("t3_drop_valid", 32'(inst_valid), 32'h0);
      check("t3_drop_inst", inst, 32'hA500_0004);
      check("t3_req", 32'(imem_req), 32'h1);
      check("t3_addr", imem_addr, 32'h100);
      tick(); tick();
      check("t3_inst", inst, 32'hA500_0100);
      check("t3_inst_pc", inst_pc, 32'h100);

      // 4: simultaneous exception, branch and jump with inst_pc=0x20 held
      jump_valid = 1'b1; jump_target = 32'h20;
      tick();
      jump_valid = 1'b0;
      tick();
      check("t4_jaddr", imem_addr, 32'h20);
      check("t4_jvalid", 32'(inst_valid), 32'h0);
      tick();
      stall = 1'b1;
      tick();
      check("t4_inst_pc", inst_pc, 32'h20);
      check("t4_hold_valid", 32'(inst_valid), 32'h1);
      exc_valid = 1'b1; br_taken = 1'b1; br_target = 32'h200;
      jump_valid = 1'b1; jump_target = 32'h300;
      tick();
      exc_valid = 1'b0; br_taken = 1'b0; jump_valid = 1'b0; stall = 1'b0;
      check("t4_pc", pc, 32'h8000_0180);
      check("t4_epc", epc, 32'h20);
      check("t4_addr", imem_addr, 32'h8000_0180);
      check("t4_valid", 32'(inst_valid), 32'h0);
      check("t4_req", 32'(imem_req), 32'h1);

      // 5: PC wrap and target alignment
      jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
      tick();
      jump_valid = 1'b0;
      check("t5_pc_top", pc, 32'hFFFF_FFFC);
      tick();
      check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      tick(); tick();
      check("t5_inst_pc", inst_pc, 32'hFFFF_FFFC);
      check("t5_inst", inst, 32'h5AFF_FFFC);
      check("t5_wrap_addr", imem_addr, 32'h0);
      check("t5_wrap_pc", pc, 32'h0);
      br_taken = 1'b1; br_target = 32'h103;
      tick();
      br_taken = 1'b0;
      check("t5_align_pc", pc, 32'h100);
      tick();
      check("t5_align_addr", imem_addr, 32'h100);
      check("t5_align_req", 32'(imem_req), 32'h1);

      // 6: reset in WAIT, late response ignored
      auto_resp = 1'b0; man_rvalid = 1'b0;
      tick();
      check("t6_wait_req", 32'(imem_req), 32'h0);
      reset = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hBADC_0DE0;
      #1;
      check("t6_rst_pc", pc, 32'h0);
      check("t6_rst_epc", epc, 32'h0);
      check("t6_rst_valid", 32'(inst_valid), 32'h0);
      tick();
      reset = 1'b0;
      tick();
      check("t6_idle_valid", 32'(inst_valid), 32'h0);
      check("t6_req", 32'(imem_req), 32'h1);
      check("t6_addr", imem_addr, 32'h0);
      man_rvalid = 1'b0; auto_resp = 1'b1;
      tick(); tick();
      check("t6_valid", 32'(inst_valid), 32'h1);
      check("t6_inst", inst, 32'hA500_0000);
      check("t6_inst_pc", inst_pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
